// File: rtl/bcd_down_counter_2digits_pkg.sv
// Shared definitions for the lab counters: FSM encodings, BCD digit limit and digit clamp helper.
package lab6_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'b00;
  localparam state_t RUN    = 2'b01;
  localparam state_t PAUSED = 2'b10;
  localparam state_t DONE   = 2'b11;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Any nibble above 9 is clamped to 9 so the counter never holds a non-BCD digit.
  function automatic logic [3:0] bcd_sanitise(input logic [3:0] digit);
    return (digit > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : digit;
  endfunction

endpackage

// File: rtl/bcd_down_counter_2digits_if.sv
// Control/status bundle of the two-digit BCD down-counter; state is exported for observation.
interface bcd_down_counter_2digits_if;
  import lab6_pkg::*;

  // Control inputs are level signals sampled on the falling clk edge; there is no
  // ready back-pressure: a request is taken on every falling edge it is high.
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic [7:0] count;
  logic       busy;
  logic       done;
  state_t     state;

  modport master (
    output load, load_val, start, pause,
    input  count, busy, done, state
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, busy, done, state
  );

endinterface

// File: rtl/bcd_down_counter_2digits_digit_down.sv
// One BCD digit counting down 9..0 on the falling clk edge; borrow_out flags a digit of 0.
module bcd_digit_down
  import lab6_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit <= 4'd0;
    end else if (ld) begin
      digit <= bcd_sanitise(ld_val);
    end else if (en) begin
      digit <= (digit == 4'd0) ? BCD_MAX_DIGIT : digit - 4'd1;
    end
  end

  // A decrement of a zero digit wraps to 9 and must borrow from the next digit.
  assign borrow_out = (digit == 4'd0);

endmodule

// File: rtl/bcd_down_counter_2digits.sv
// Loadable two-digit BCD down-counter (99..00) with pause, prescaler and done pulse.
// Optional macro BCD_AUTO_RELOAD_EN restarts from the last loaded value on reaching 00.
module bcd_down_counter_2digits
  import lab6_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  bcd_down_counter_2digits_if.slave   bus
);

  localparam logic [3:0] TICK_LAST = 4'(TICK_DIV - 1);

  state_t     state, state_nxt;
  logic [3:0] presc, presc_nxt;
  logic       done_q, done_nxt;
  logic [3:0] ones, tens;
  logic       ones_borrow, tens_borrow;
  logic       count_zero;
  logic [7:0] load_san;
  logic       dig_ld;
  logic [7:0] dig_ld_val;
  logic       dec;
  logic       tick;

  assign load_san   = {bcd_sanitise(bus.load_val[7:4]), bcd_sanitise(bus.load_val[3:0])};
  assign count_zero = ones_borrow & tens_borrow;
  assign tick       = (presc == TICK_LAST);

`ifdef BCD_AUTO_RELOAD_EN
  logic [7:0] reload_q;

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= 8'h00;
    end else if (bus.load) begin
      reload_q <= load_san;
    end
  end
`endif

  always_comb begin
    state_nxt  = state;
    presc_nxt  = presc;
    done_nxt   = 1'b0;
    dig_ld     = 1'b0;
    dig_ld_val = load_san;
    dec        = 1'b0;
    case (state)
      // DONE lasts one edge and then reacts to load/start exactly like IDLE.
      IDLE, DONE: begin
        presc_nxt = 4'd0;
        dig_ld    = bus.load;
        if (bus.start && (bus.load ? (load_san != 8'h00) : !count_zero)) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (bus.load) begin
          dig_ld    = 1'b1;
          presc_nxt = 4'd0;
        end else if (bus.pause) begin
          state_nxt = PAUSED;
        end else if (tick) begin
          presc_nxt = 4'd0;
          if (count_zero) begin
            // 00 is terminal: never decremented, just drop back to IDLE.
            state_nxt = IDLE;
          end else if (ones == 4'd1 && tens == 4'd0) begin
            done_nxt = 1'b1;
`ifdef BCD_AUTO_RELOAD_EN
            if (reload_q != 8'h00) begin
              dig_ld     = 1'b1;
              dig_ld_val = reload_q;
            end else begin
              dec       = 1'b1;
              state_nxt = DONE;
            end
`else
            dec       = 1'b1;
            state_nxt = DONE;
`endif
          end else begin
            dec = 1'b1;
          end
        end else begin
          presc_nxt = presc + 4'd1;
        end
      end
      PAUSED: begin
        if (bus.load) begin
          dig_ld    = 1'b1;
          presc_nxt = 4'd0;
        end
        if (!bus.pause && bus.start) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      presc  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      presc  <= presc_nxt;
      done_q <= done_nxt;
    end
  end

  bcd_digit_down u_ones (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (dec),
    .ld         (dig_ld),
    .ld_val     (dig_ld_val[3:0]),
    .digit      (ones),
    .borrow_out (ones_borrow)
  );

  // Tens only moves when the ones digit wraps from 0 to 9.
  bcd_digit_down u_tens (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (dec & ones_borrow),
    .ld         (dig_ld),
    .ld_val     (dig_ld_val[7:4]),
    .digit      (tens),
    .borrow_out (tens_borrow)
  );

  assign bus.count = {tens, ones};
  assign bus.busy  = (state == RUN);
  assign bus.done  = done_q;
  assign bus.state = state;

endmodule

// File: tb/tb_bcd_down_counter_2digits.sv
// Directed bench for bcd_down_counter_2digits: TICK_DIV=1 instance (a) and TICK_DIV=3 instance (b).
module tb_bcd_down_counter_2digits;
  import lab6_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  bcd_down_counter_2digits_if a_if ();
  bcd_down_counter_2digits_if b_if ();

  bcd_down_counter_2digits #(.TICK_DIV(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a_if));
  bcd_down_counter_2digits #(.TICK_DIV(3)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b_if));

  // Clock/reset: DUT acts on negedge, bench drives and samples just after posedge.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic edge_step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic drive_a(input logic ld, input logic [7:0] val, input logic st, input logic ps);
    a_if.load = ld; a_if.load_val = val; a_if.start = st; a_if.pause = ps;
  endtask

  task automatic drive_b(input logic ld, input logic [7:0] val, input logic st, input logic ps);
    b_if.load = ld; b_if.load_val = val; b_if.start = st; b_if.pause = ps;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_a(0, 8'h00, 0, 0);
    drive_b(0, 8'h00, 0, 0);
    reset_n = 1'b0;
    #1;
    checks++; if (a_if.count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", a_if.count); end
    checks++; if (a_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_if.busy); end
    checks++; if (a_if.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", a_if.done); end
    checks++; if (a_if.state !== IDLE) begin failures++; $display("FAIL reset_state got=%b exp=%b", a_if.state, IDLE); end
    checks++; if (b_if.count !== 8'h00) begin failures++; $display("FAIL reset_count_b got=%h exp=00", b_if.count); end
    @(posedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_full_countdown();
    logic [7:0] seq [12];
    seq = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    drive_a(1, 8'h12, 0, 0);
    edge_step();
    checks++; if (a_if.count !== 8'h12) begin failures++; $display("FAIL full_load got=%h exp=12", a_if.count); end
    checks++; if (a_if.busy !== 1'b0) begin failures++; $display("FAIL full_load_busy got=%b exp=0", a_if.busy); end
    drive_a(0, 8'h00, 1, 0);
    edge_step();
    checks++; if (a_if.count !== 8'h12) begin failures++; $display("FAIL full_start_count got=%h exp=12", a_if.count); end
    checks++; if (a_if.busy !== 1'b1) begin failures++; $display("FAIL full_start_busy got=%b exp=1", a_if.busy); end
    drive_a(0, 8'h00, 0, 0);
    for (int i = 0; i < 12; i++) begin
      edge_step();
      checks++; if (a_if.count !== seq[i]) begin failures++; $display("FAIL full_seq[%0d] got=%h exp=%h", i, a_if.count, seq[i]); end
      checks++; if (a_if.done !== (i == 11)) begin failures++; $display("FAIL full_done[%0d] got=%b exp=%b", i, a_if.done, (i == 11)); end
      checks++; if (a_if.busy !== (i != 11)) begin failures++; $display("FAIL full_busy[%0d] got=%b exp=%b", i, a_if.busy, (i != 11)); end
    end
    edge_step();
    checks++; if (a_if.state !== IDLE) begin failures++; $display("FAIL full_idle got=%b exp=%b", a_if.state, IDLE); end
    checks++; if (a_if.done !== 1'b0) begin failures++; $display("FAIL full_done_after got=%b exp=0", a_if.done); end
    edge_step();
    checks++; if (a_if.count !== 8'h00) begin failures++; $display("FAIL full_hold got=%h exp=00", a_if.count); end
  endtask

  task automatic test_zero_start();
    drive_a(0, 8'h00, 1, 0);
    edge_step();
    checks++; if (a_if.state !== IDLE) begin failures++; $display("FAIL zero_start_state got=%b exp=%b", a_if.state, IDLE); end
    checks++; if (a_if.done !== 1'b0) begin failures++; $display("FAIL zero_start_done got=%b exp=0", a_if.done); end
    drive_a(0, 8'h00, 0, 0);
  endtask

  task automatic test_pause();
    logic [7:0] seq [3];
    seq = '{8'h29, 8'h28, 8'h27};
    drive_a(1, 8'h30, 0, 0);
    edge_step();
    drive_a(0, 8'h00, 1, 0);
    edge_step();
    drive_a(0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      checks++; if (a_if.count !== seq[i]) begin failures++; $display("FAIL pause_run[%0d] got=%h exp=%h", i, a_if.count, seq[i]); end
    end
    drive_a(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) begin
      edge_step();
      checks++; if (a_if.count !== 8'h27) begin failures++; $display("FAIL pause_hold[%0d] got=%h exp=27", i, a_if.count); end
      checks++; if (a_if.busy !== 1'b0) begin failures++; $display("FAIL pause_busy[%0d] got=%b exp=0", i, a_if.busy); end
    end
    drive_a(0, 8'h00, 1, 0);
    edge_step();
    checks++; if (a_if.state !== RUN) begin failures++; $display("FAIL resume_state got=%b exp=%b", a_if.state, RUN); end
    checks++; if (a_if.count !== 8'h27) begin failures++; $display("FAIL resume_count got=%h exp=27", a_if.count); end
    drive_a(0, 8'h00, 0, 0);
    edge_step();
    checks++; if (a_if.count !== 8'h26) begin failures++; $display("FAIL resume_dec got=%h exp=26", a_if.count); end
  endtask

  task automatic test_sanitise_priority();
    drive_a(1, 8'h05, 0, 0);
    edge_step();
    checks++; if (a_if.count !== 8'h05) begin failures++; $display("FAIL run_load got=%h exp=05", a_if.count); end
    drive_a(1, 8'hB7, 0, 0);
    edge_step();
    checks++; if (a_if.count !== 8'h97) begin failures++; $display("FAIL sanitise_b7 got=%h exp=97", a_if.count); end
    checks++; if (a_if.busy !== 1'b1) begin failures++; $display("FAIL sanitise_busy got=%b exp=1", a_if.busy); end
    drive_a(0, 8'h00, 0, 0);
    edge_step();
    checks++; if (a_if.count !== 8'h96) begin failures++; $display("FAIL after_load_1 got=%h exp=96", a_if.count); end
    edge_step();
    checks++; if (a_if.count !== 8'h95) begin failures++; $display("FAIL after_load_2 got=%h exp=95", a_if.count); end
    drive_a(1, 8'h7F, 0, 1);
    edge_step();
    checks++; if (a_if.count !== 8'h79) begin failures++; $display("FAIL sanitise_7f got=%h exp=79", a_if.count); end
    checks++; if (a_if.state !== RUN) begin failures++; $display("FAIL load_over_pause got=%b exp=%b", a_if.state, RUN); end
    drive_a(0, 8'h00, 0, 1);
    edge_step();
    checks++; if (a_if.state !== PAUSED) begin failures++; $display("FAIL enter_pause got=%b exp=%b", a_if.state, PAUSED); end
    drive_a(1, 8'h42, 0, 1);
    edge_step();
    checks++; if (a_if.count !== 8'h42) begin failures++; $display("FAIL paused_load got=%h exp=42", a_if.count); end
    checks++; if (a_if.state !== PAUSED) begin failures++; $display("FAIL paused_load_state got=%b exp=%b", a_if.state, PAUSED); end
    drive_a(0, 8'h00, 1, 1);
    edge_step();
    checks++; if (a_if.state !== PAUSED) begin failures++; $display("FAIL pause_start_state got=%b exp=%b", a_if.state, PAUSED); end
    drive_a(0, 8'h00, 1, 0);
    edge_step();
    drive_a(0, 8'h00, 0, 0);
    edge_step();
    checks++; if (a_if.count !== 8'h41) begin failures++; $display("FAIL paused_resume got=%h exp=41", a_if.count); end
  endtask

  task automatic test_reset_mid_run();
    drive_a(1, 8'h45, 1, 0);
    edge_step();
    drive_a(0, 8'h00, 0, 0);
    edge_step();
    checks++; if (a_if.count !== 8'h44) begin failures++; $display("FAIL mid_pre got=%h exp=44", a_if.count); end
    reset_n = 1'b0;
    #1;
    checks++; if (a_if.count !== 8'h00) begin failures++; $display("FAIL mid_reset_count got=%h exp=00", a_if.count); end
    checks++; if (a_if.busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", a_if.busy); end
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_load_start_same();
    drive_a(1, 8'h03, 1, 0);
    edge_step();
    checks++; if (a_if.count !== 8'h03) begin failures++; $display("FAIL ls_count got=%h exp=03", a_if.count); end
    checks++; if (a_if.state !== RUN) begin failures++; $display("FAIL ls_state got=%b exp=%b", a_if.state, RUN); end
    drive_a(0, 8'h00, 0, 0);
    edge_step();
    checks++; if (a_if.count !== 8'h02) begin failures++; $display("FAIL ls_dec got=%h exp=02", a_if.count); end
    pulse_reset();
  endtask

  task automatic test_prescaler();
    logic [7:0] seq [6];
    seq = '{8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h00};
    drive_b(1, 8'h02, 0, 0);
    edge_step();
    drive_b(0, 8'h00, 1, 0);
    edge_step();
    drive_b(0, 8'h00, 0, 0);
    for (int i = 0; i < 6; i++) begin
      edge_step();
      checks++; if (b_if.count !== seq[i]) begin failures++; $display("FAIL presc_seq[%0d] got=%h exp=%h", i, b_if.count, seq[i]); end
      checks++; if (b_if.done !== (i == 5)) begin failures++; $display("FAIL presc_done[%0d] got=%b exp=%b", i, b_if.done, (i == 5)); end
    end
    edge_step();
    checks++; if (b_if.done !== 1'b0) begin failures++; $display("FAIL presc_done_after got=%b exp=0", b_if.done); end
    checks++; if (b_if.state !== IDLE) begin failures++; $display("FAIL presc_idle got=%b exp=%b", b_if.state, IDLE); end
  endtask

  task automatic test_auto_reload();
    logic [7:0] seq [4];
    seq = '{8'h01, 8'h02, 8'h01, 8'h02};
    drive_a(1, 8'h02, 0, 0);
    edge_step();
    drive_a(0, 8'h00, 1, 0);
    edge_step();
    drive_a(0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      edge_step();
      checks++; if (a_if.count !== seq[i]) begin failures++; $display("FAIL reload_seq[%0d] got=%h exp=%h", i, a_if.count, seq[i]); end
      checks++; if (a_if.done !== (i % 2 == 1)) begin failures++; $display("FAIL reload_done[%0d] got=%b exp=%b", i, a_if.done, (i % 2 == 1)); end
      checks++; if (a_if.busy !== 1'b1) begin failures++; $display("FAIL reload_busy[%0d] got=%b exp=1", i, a_if.busy); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
`ifdef BCD_AUTO_RELOAD_EN
    test_auto_reload();
    pulse_reset();
`else
    test_full_countdown();
    test_zero_start();
    test_prescaler();
`endif
    test_pause();
    test_sanitise_priority();
    test_reset_mid_run();
    test_load_start_same();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
